// File: rtl/fft_spi_scheduler.sv
// Frames one FFT result (sync, count, 2*N words) onto the byte-wide SPI master; SYNC DV two cycles after done.
// Backpressure: each byte waits for i_tx_ready high, then its low/high handshake; the result bus is held meanwhile.
`timescale 1ns/1ps
module fft_spi_scheduler #(
    parameter int             N         = 16,
    parameter int             MSB       = 8,
    parameter logic [MSB-1:0] SYNC_BYTE = 8'hA5
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_fft_done,
    input  logic [MSB-1:0]         i_word,
    input  logic                   i_tx_ready,
    input  logic                   i_clr_overrun,
    output logic [$clog2(2*N)-1:0] o_addr,
    output logic [MSB-1:0]         o_tx_byte,
    output logic                   o_tx_dv,
    output logic                   o_fft_hold,
    output logic                   o_busy,
    output logic [7:0]             o_frame_cnt,
    output logic                   o_overrun
);
    localparam int             AW        = $clog2(2*N);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(2*N-1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_CNT     = 3'd2,
        S_DATA    = 3'd3,
        S_WAIT_LO = 3'd4,
        S_WAIT_HI = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t r_state;
    state_t r_last;
    state_t w_state_nxt;
    state_t w_last_nxt;

    logic [AW-1:0]  w_addr;
    logic [MSB-1:0] w_tx_byte;
    logic           w_tx_dv;
    logic           w_fft_hold;
    logic           w_busy;
    logic [7:0]     w_frame_cnt;
    logic           w_overrun;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state     <= S_IDLE;
            r_last      <= S_IDLE;
            o_addr      <= '0;
            o_tx_byte   <= '0;
            o_tx_dv     <= 1'b0;
            o_fft_hold  <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_cnt <= 8'd0;
            o_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            o_addr      <= w_addr;
            o_tx_byte   <= w_tx_byte;
            o_tx_dv     <= w_tx_dv;
            o_fft_hold  <= w_fft_hold;
            o_busy      <= w_busy;
            o_frame_cnt <= w_frame_cnt;
            o_overrun   <= w_overrun;
        end
    end

    // r_last remembers which issue state sent the byte now in the SPI handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (i_fft_done) w_state_nxt = S_SYNC;
            end
            S_SYNC, S_CNT, S_DATA: begin
                if (i_tx_ready) begin
                    w_state_nxt = S_WAIT_LO;
                    w_last_nxt  = r_state;
                end
            end
            S_WAIT_LO: begin
                if (!i_tx_ready) w_state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (i_tx_ready) begin
                    case (r_last)
                        S_SYNC:  w_state_nxt = S_CNT;
                        S_CNT:   w_state_nxt = S_DATA;
                        default: w_state_nxt = (o_addr == LAST_ADDR) ? S_DONE : S_DATA;
                    endcase
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr      = o_addr;
        w_tx_byte   = o_tx_byte;
        w_tx_dv     = 1'b0;
        w_fft_hold  = o_fft_hold;
        w_frame_cnt = o_frame_cnt;
        w_busy      = (w_state_nxt != S_IDLE);
        // A done pulse while busy (DONE cycle included) is dropped; set beats clear.
        if (i_fft_done && o_busy)
            w_overrun = 1'b1;
        else if (i_clr_overrun)
            w_overrun = 1'b0;
        else
            w_overrun = o_overrun;
        case (r_state)
            S_IDLE: begin
                if (i_fft_done) begin
                    w_fft_hold = 1'b1;
                    w_addr     = '0;
                end
            end
            S_SYNC: begin
                if (i_tx_ready) begin
                    w_tx_dv   = 1'b1;
                    w_tx_byte = SYNC_BYTE;
                end
            end
            S_CNT: begin
                if (i_tx_ready) begin
                    w_tx_dv   = 1'b1;
                    w_tx_byte = MSB'(o_frame_cnt);
                end
            end
            S_DATA: begin
                if (i_tx_ready) begin
                    w_tx_dv   = 1'b1;
                    w_tx_byte = i_word;
                end
            end
            S_WAIT_HI: begin
                if (i_tx_ready) begin
                    if (r_last == S_CNT)
                        w_addr = '0;
                    else if (r_last == S_DATA && o_addr != LAST_ADDR)
                        w_addr = o_addr + AW'(1);
                end
            end
            S_DONE: begin
                w_frame_cnt = o_frame_cnt + 8'd1;
                w_fft_hold  = 1'b0;
                w_addr      = '0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fft_spi_scheduler.sv
// Directed bench for fft_spi_scheduler: a reactive SPI-master ready model records every DV byte,
// and hand-computed frame contents, counts and flags are compared through one check task.
`timescale 1ns/1ps
module tb_fft_spi_scheduler;
    localparam int N  = 16;
    localparam int NW = 2*N;
    localparam int AW = $clog2(NW);

    logic          i_Clk = 1'b0;
    logic          i_Rst_L;
    logic          i_fft_done;
    logic [7:0]    i_word;
    logic          i_tx_ready;
    logic          i_clr_overrun;
    logic [AW-1:0] o_addr;
    logic [7:0]    o_tx_byte;
    logic          o_tx_dv;
    logic          o_fft_hold;
    logic          o_busy;
    logic [7:0]    o_frame_cnt;
    logic          o_overrun;

    logic [7:0] bus [NW];
    assign i_word = bus[o_addr];

    fft_spi_scheduler #(.N(N), .MSB(8), .SYNC_BYTE(8'hA5)) dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_fft_done    (i_fft_done),
        .i_word        (i_word),
        .i_tx_ready    (i_tx_ready),
        .i_clr_overrun (i_clr_overrun),
        .o_addr        (o_addr),
        .o_tx_byte     (o_tx_byte),
        .o_tx_dv       (o_tx_dv),
        .o_fft_hold    (o_fft_hold),
        .o_busy        (o_busy),
        .o_frame_cnt   (o_frame_cnt),
        .o_overrun     (o_overrun)
    );

    always #5 i_Clk = ~i_Clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SPI master model: ready drops the cycle after a DV and stays low for low_len cycles.
    logic [7:0] byte_q [$];
    int  low_len   = 16;
    int  rdy_cnt   = 0;
    bit  drop_pend = 1'b0;
    bit  dv_prev   = 1'b0;
    bit  hold_low  = 1'b0;
    int  viol_rdy  = 0;
    int  viol_b2b  = 0;

    initial begin : spi_model
        i_tx_ready = 1'b1;
        forever begin
            @(negedge i_Clk);
            if (o_tx_dv) begin
                if (!i_tx_ready) viol_rdy++;
                if (dv_prev) viol_b2b++;
                byte_q.push_back(o_tx_byte);
                drop_pend = 1'b1;
            end else if (drop_pend) begin
                drop_pend = 1'b0;
                rdy_cnt   = low_len;
            end else if (rdy_cnt > 0) begin
                rdy_cnt--;
            end
            dv_prev    = o_tx_dv;
            i_tx_ready = !hold_low && (rdy_cnt == 0);
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1);
    end

    function automatic logic [7:0] qb(input int i);
        if (i < byte_q.size()) return byte_q[i];
        return 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic pulse_done();
        byte_q.delete();
        i_fft_done = 1'b1;
        @(negedge i_Clk);
        i_fft_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            @(negedge i_Clk);
            n++;
        end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dv"},    32'(o_tx_dv),     32'd0);
        check({tag, "_byte"},  32'(o_tx_byte),   32'd0);
        check({tag, "_addr"},  32'(o_addr),      32'd0);
        check({tag, "_hold"},  32'(o_fft_hold),  32'd0);
        check({tag, "_busy"},  32'(o_busy),      32'd0);
        check({tag, "_cnt"},   32'(o_frame_cnt), 32'd0);
        check({tag, "_ovr"},   32'(o_overrun),   32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] cnt_byte);
        check({tag, "_len"},  32'(byte_q.size()), 32'd34);
        check({tag, "_sync"}, 32'(qb(0)), 32'hA5);
        check({tag, "_cnt"},  32'(qb(1)), 32'(cnt_byte));
    endtask

    initial begin : main
        int n;
        int bad;
        for (int i = 0; i < NW; i++) bus[i] = 8'(i);
        i_Rst_L       = 1'b0;
        i_fft_done    = 1'b0;
        i_clr_overrun = 1'b0;
        tick(3);
        check_reset_outputs("rst");
        i_Rst_L = 1'b1;
        tick(2);

        // Frame 1: two-cycle latency to SYNC DV, then full content.
        pulse_done();
        check("f1_busy_lat1", 32'(o_busy), 32'd1);
        check("f1_hold_lat1", 32'(o_fft_hold), 32'd1);
        check("f1_dv_lat1",   32'(o_tx_dv), 32'd0);
        tick(1);
        check("f1_dv_lat2",   32'(o_tx_dv), 32'd1);
        check("f1_byte_lat2", 32'(o_tx_byte), 32'hA5);
        tick(300);
        check("f1_hold_mid",  32'(o_fft_hold), 32'd1);
        wait_idle("f1_idle", 3000);
        check_frame("f1", 8'h00);
        if (byte_q.size() == 34)
            for (int i = 0; i < NW; i++) check($sformatf("f1_data%0d", i), 32'(qb(i+2)), 32'(i));
        check("f1_frame_cnt", 32'(o_frame_cnt), 32'd1);
        check("f1_hold_end",  32'(o_fft_hold), 32'd0);

        // Ready held low through SYNC.
        #1 hold_low = 1'b1;
        tick(1);
        pulse_done();
        tick(50);
        check("hl_no_dv_cnt", 32'(byte_q.size()), 32'd0);
        check("hl_busy",      32'(o_busy), 32'd1);
        #1 hold_low = 1'b0;
        tick(1);
        check("hl_dv_before", 32'(o_tx_dv), 32'd0);
        tick(1);
        check("hl_dv_after",  32'(o_tx_dv), 32'd1);
        check("hl_byte",      32'(o_tx_byte), 32'hA5);
        wait_idle("hl_idle", 3000);
        check_frame("hl", 8'h01);
        check("hl_frame_cnt", 32'(o_frame_cnt), 32'd2);

        // Overrun: second done pulse at byte 10.
        pulse_done();
        n = 0;
        while (byte_q.size() < 10 && n < 1000) begin tick(1); n++; end
        check("ov_reach10", 32'(byte_q.size() >= 10), 32'd1);
        i_fft_done = 1'b1;
        tick(1);
        i_fft_done = 1'b0;
        check("ov_set", 32'(o_overrun), 32'd1);
        wait_idle("ov_idle", 3000);
        check_frame("ov", 8'h02);
        check("ov_frame_cnt", 32'(o_frame_cnt), 32'd3);
        tick(5);
        check("ov_no_restart", 32'(o_busy), 32'd0);
        check("ov_cnt_stable", 32'(o_frame_cnt), 32'd3);
        check("ov_sticky",     32'(o_overrun), 32'd1);

        // Clear together with a busy done: set wins; then a lone clear.
        pulse_done();
        tick(3);
        i_fft_done    = 1'b1;
        i_clr_overrun = 1'b1;
        tick(1);
        i_fft_done    = 1'b0;
        i_clr_overrun = 1'b0;
        check("clr_set_wins", 32'(o_overrun), 32'd1);
        i_clr_overrun = 1'b1;
        tick(1);
        i_clr_overrun = 1'b0;
        check("clr_alone", 32'(o_overrun), 32'd0);
        wait_idle("clr_idle", 3000);
        check_frame("clr", 8'h03);
        check("clr_frame_cnt", 32'(o_frame_cnt), 32'd4);

        // Back-to-back: done in the first IDLE cycle after DONE.
        pulse_done();
        wait_idle("b2b_first_idle", 3000);
        check_frame("b2b_first", 8'h04);
        pulse_done();
        check("b2b_busy", 32'(o_busy), 32'd1);
        check("b2b_ovr",  32'(o_overrun), 32'd0);
        tick(1);
        check("b2b_dv_lat",   32'(o_tx_dv), 32'd1);
        check("b2b_byte_lat", 32'(o_tx_byte), 32'hA5);
        wait_idle("b2b_idle", 3000);
        check_frame("b2b", 8'h05);
        check("b2b_frame_cnt", 32'(o_frame_cnt), 32'd6);

        // Reset mid-frame in DATA at addr 7.
        pulse_done();
        n = 0;
        while (!(o_addr == AW'(7) && o_busy) && n < 2000) begin tick(1); n++; end
        check("mr_reach7", 32'(o_addr), 32'd7);
        i_Rst_L = 1'b0;
        tick(1);
        i_Rst_L = 1'b1;
        check_reset_outputs("mr");
        check("mr_bytes_before", 32'(byte_q.size()), 32'd9);
        tick(20);
        check("mr_no_reissue", 32'(byte_q.size()), 32'd9);
        pulse_done();
        wait_idle("mr_idle", 3000);
        check_frame("mr", 8'h00);
        check("mr_data0", 32'(qb(2)), 32'h00);
        check("mr_data31", 32'(qb(33)), 32'h1F);
        check("mr_frame_cnt", 32'(o_frame_cnt), 32'd1);

        // Frame-count wrap over 257 frames with a fast ready model.
        low_len = 1;
        i_Rst_L = 1'b0;
        tick(2);
        i_Rst_L = 1'b1;
        tick(3);
        bad = 0;
        for (int f = 0; f < 257; f++) begin
            pulse_done();
            n = 0;
            while (o_busy && n < 1000) begin tick(1); n++; end
            if (o_busy || byte_q.size() != 34 || qb(1) !== 8'(f)) bad++;
            if (f == 255) check("wrap_cnt255", 32'(qb(1)), 32'hFF);
            if (f == 256) check("wrap_cnt256", 32'(qb(1)), 32'h00);
        end
        check("wrap_bad_frames", 32'(bad), 32'd0);
        check("wrap_frame_cnt", 32'(o_frame_cnt), 32'd1);

        check("dv_while_not_ready", 32'(viol_rdy), 32'd0);
        check("dv_back_to_back",    32'(viol_b2b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
